// File: rtl/lcd_frame_streamer_pkg.sv
// Shared definitions for the LCD frame streamer: FSM states, opcodes and
// the controller power-up init sequence.
package lcd_frame_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_PRE, ST_FETCH, ST_LATCH, ST_SEND, ST_DONE
  } state_t;

  localparam int INIT_LEN = 13;

  localparam logic [7:0] PAGE_ADDR = 8'hB0;
  localparam logic [7:0] COL_HI    = 8'h10;
  localparam logic [7:0] COL_LO    = 8'h00;

  // bit8 of an output word: 1 = instruction, 0 = display data
  localparam logic INST = 1'b1;
  localparam logic DATA = 1'b0;

  // index 0 is the first byte sent
  localparam logic [INIT_LEN-1:0][7:0] INIT_BYTES = {
    8'hAF, 8'h90, 8'hFA, 8'h10, 8'h81, 8'h27, 8'h2F,
    8'hA2, 8'hA6, 8'hA4, 8'hC0, 8'hA1, 8'h40
  };

endpackage

// File: rtl/lcd_frame_streamer_init_rom.sv
// Combinational init-sequence ROM: 4-bit index -> command byte.
module lcd_init_rom
  import lcd_frame_streamer_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] data
);

  always_comb begin
    data = 8'h00;
    case (idx)
      4'd0:  data = INIT_BYTES[0];
      4'd1:  data = INIT_BYTES[1];
      4'd2:  data = INIT_BYTES[2];
      4'd3:  data = INIT_BYTES[3];
      4'd4:  data = INIT_BYTES[4];
      4'd5:  data = INIT_BYTES[5];
      4'd6:  data = INIT_BYTES[6];
      4'd7:  data = INIT_BYTES[7];
      4'd8:  data = INIT_BYTES[8];
      4'd9:  data = INIT_BYTES[9];
      4'd10: data = INIT_BYTES[10];
      4'd11: data = INIT_BYTES[11];
      4'd12: data = INIT_BYTES[12];
      default: data = 8'h00;
    endcase
  end

endmodule

// File: rtl/lcd_frame_streamer.sv
// Streams an optional init sequence plus a paged framebuffer into the LCD
// SPI command/data FIFO over a valid/ready word interface.
module lcd_frame_streamer
  import lcd_frame_streamer_pkg::*;
#(
  parameter int COLS       = 102,
  parameter int PAGES      = 8,
  parameter int COL_OFFSET = 0,
  parameter int FB_AW      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             init_en,
  output logic             busy,
  output logic             done,
  output logic             fb_rd,
  output logic [FB_AW-1:0] fb_addr,
  input  logic [7:0]       fb_rdata,
  output logic [8:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = (COLS  > 1) ? $clog2(COLS)  : 1;
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam logic [7:0] COL_ADDR = 8'(COL_OFFSET);

  state_t          state, state_nxt;
  logic [3:0]      idx;
  logic [1:0]      pre_idx;
  logic [CW-1:0]   col;
  logic [PW-1:0]   page;
  logic [7:0]      rom_byte;
  logic [7:0]      pre_byte;
  logic            xfer, col_last, page_last;

  lcd_init_rom u_rom (.idx(idx), .data(rom_byte));

  assign xfer      = out_valid & out_ready;
  assign col_last  = (col  == CW'(COLS - 1));
  assign page_last = (page == PW'(PAGES - 1));

  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);
  assign fb_rd = (state == ST_FETCH);

  always_comb begin
    pre_byte = COL_LO | {4'h0, COL_ADDR[3:0]};
    case (pre_idx)
      2'd0:    pre_byte = PAGE_ADDR | 8'(page);
      2'd1:    pre_byte = COL_HI | {4'h0, COL_ADDR[7:4]};
      default: pre_byte = COL_LO | {4'h0, COL_ADDR[3:0]};
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = init_en ? ST_INIT : ST_PRE;
      ST_INIT:  if (xfer && idx == 4'(INIT_LEN - 1)) state_nxt = ST_PRE;
      ST_PRE:   if (xfer && pre_idx == 2'd2) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_SEND;
      ST_SEND:
        if (xfer) begin
          if (!col_last)      state_nxt = ST_FETCH;
          else if (!page_last) state_nxt = ST_PRE;
          else                state_nxt = ST_DONE;
        end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Words are registered and only reloaded once the previous one has gone,
  // so out_ready never reaches out_valid/out_data combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      pre_idx   <= '0;
      col       <= '0;
      page      <= '0;
      fb_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (xfer) out_valid <= 1'b0;
      case (state)
        ST_INIT:
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= {INST, rom_byte};
          end else if (xfer) begin
            idx <= idx + 4'd1;
          end
        ST_PRE:
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= {INST, pre_byte};
          end else if (xfer) begin
            pre_idx <= (pre_idx == 2'd2) ? 2'd0 : pre_idx + 2'd1;
          end
        ST_LATCH: begin
          out_valid <= 1'b1;
          out_data  <= {DATA, fb_rdata};
        end
        ST_SEND:
          if (xfer) begin
            fb_addr <= fb_addr + FB_AW'(1);
            if (col_last) begin
              col <= '0;
              if (!page_last) page <= page + PW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        ST_DONE: begin
          idx     <= '0;
          pre_idx <= '0;
          col     <= '0;
          page    <= '0;
          fb_addr <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Directed bench for lcd_frame_streamer: three parameterisations share one
// framebuffer model, sink model and word recorder selected by 'sel'.
module tb_lcd_frame_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, init_en = 1'b0, out_ready = 1'b0;
  logic [7:0] fb_rdata;
  int sel = 0;
  int mode = 0;  // 0 ready=1, 1 random+stall, 2 FIFO sink

  logic b0, b1, b2, dn0, dn1, dn2, r0, r1, r2, v0, v1, v2;
  logic [9:0] a0, a1;
  logic [5:0] a2;
  logic [8:0] d0, d1, d2;

  lcd_frame_streamer dut0 (
    .clk(clk), .rst(rst), .start(start && sel == 0), .init_en(init_en),
    .busy(b0), .done(dn0), .fb_rd(r0), .fb_addr(a0), .fb_rdata(fb_rdata),
    .out_data(d0), .out_valid(v0), .out_ready(out_ready));

  lcd_frame_streamer #(.COL_OFFSET(30)) dut1 (
    .clk(clk), .rst(rst), .start(start && sel == 1), .init_en(init_en),
    .busy(b1), .done(dn1), .fb_rd(r1), .fb_addr(a1), .fb_rdata(fb_rdata),
    .out_data(d1), .out_valid(v1), .out_ready(out_ready));

  // 16*4 = 2^6: exercises the full-address-space wrap
  lcd_frame_streamer #(.COLS(16), .PAGES(4), .FB_AW(6)) dut2 (
    .clk(clk), .rst(rst), .start(start && sel == 2), .init_en(init_en),
    .busy(b2), .done(dn2), .fb_rd(r2), .fb_addr(a2), .fb_rdata(fb_rdata),
    .out_data(d2), .out_valid(v2), .out_ready(out_ready));

  logic       busy_s, done_s, rd_s, vld_s;
  logic [9:0] addr_s;
  logic [8:0] data_s;
  assign busy_s = (sel == 0) ? b0  : (sel == 1) ? b1  : b2;
  assign done_s = (sel == 0) ? dn0 : (sel == 1) ? dn1 : dn2;
  assign rd_s   = (sel == 0) ? r0  : (sel == 1) ? r1  : r2;
  assign vld_s  = (sel == 0) ? v0  : (sel == 1) ? v1  : v2;
  assign addr_s = (sel == 0) ? a0  : (sel == 1) ? a1  : {4'h0, a2};
  assign data_s = (sel == 0) ? d0  : (sel == 1) ? d1  : d2;

  logic [7:0] fb [1024];
  initial for (int i = 0; i < 1024; i++) fb[i] = 8'(i);
  always @(posedge clk) if (rd_s) fb_rdata <= fb[addr_s];

  logic [7:0] rom_ref [13] = '{8'h40, 8'hA1, 8'hC0, 8'hA4, 8'hA6, 8'hA2,
                               8'h2F, 8'h27, 8'h81, 8'h10, 8'hFA, 8'h90, 8'hAF};

  logic [8:0] got[$];
  logic [8:0] fifo_q[$];
  int nwords, ndone, nfbrd, hold_viol, full_hits, stall_cnt, dcyc;
  bit stalled_once, prev_stall;
  logic [8:0] prev_data;
  int asserts = 0, fails = 0;

  // Inputs for the coming posedge are decided here, at the negedge, and
  // the transfer that edge will perform is recorded at the same time.
  always @(negedge clk) begin
    case (mode)
      1: begin
        if (stall_cnt > 0) begin
          out_ready = 1'b0;
          stall_cnt--;
        end else if (nwords == 500 && !stalled_once) begin
          stalled_once = 1'b1;
          stall_cnt = 499;
          out_ready = 1'b0;
        end else begin
          out_ready = ($urandom_range(0, 9) < 3);
        end
      end
      2: out_ready = (fifo_q.size() < 16);
      default: out_ready = 1'b1;
    endcase
    if (prev_stall && !rst && (!vld_s || data_s !== prev_data)) hold_viol++;
    prev_stall = !rst && vld_s && !out_ready;
    prev_data  = data_s;
    if (!rst && vld_s && out_ready) begin
      nwords++;
      if (mode == 2) fifo_q.push_back(data_s);
      else           got.push_back(data_s);
    end
    if (mode == 2) begin
      dcyc++;
      if (((dcyc / 40) % 2) == 1 && fifo_q.size() > 0) got.push_back(fifo_q.pop_front());
      if (fifo_q.size() == 16) full_hits++;
    end
    if (!rst && done_s) ndone++;
    if (!rst && rd_s) nfbrd++;
  end

  function automatic logic [8:0] exp_word(int k, bit ini, int cols, int off);
    int j, p, r;
    j = k;
    if (ini) begin
      if (k < 13) return {1'b1, rom_ref[k]};
      j = k - 13;
    end
    p = j / (cols + 3);
    r = j % (cols + 3);
    case (r)
      0: return {1'b1, 8'hB0 | 8'(p)};
      1: return {1'b1, 8'h10 | 8'((off >> 4) & 15)};
      2: return {1'b1, 8'(off & 15)};
      default: return {1'b0, 8'(p * cols + r - 3)};
    endcase
  endfunction

  function automatic int seq_errs(bit ini, int cols, int off);
    int e = 0;
    foreach (got[k]) if (got[k] !== exp_word(k, ini, cols, off)) e++;
    return e;
  endfunction

  task automatic clear_counts();
    got.delete();
    fifo_q.delete();
    nwords = 0; ndone = 0; nfbrd = 0; hold_viol = 0; full_hits = 0;
    stall_cnt = 0; dcyc = 0; stalled_once = 0; prev_stall = 0;
  endtask

  task automatic pulse_start(input bit ini);
    start = 1'b1; init_en = ini;
    @(posedge clk); #1;
    start = 1'b0; init_en = 1'b0;
  endtask

  // Waits for the selected DUT's done pulse (bounded); optional extra
  // start pulse when word 'busy_hit' is reached or in the done cycle.
  task automatic wait_done(input int budget, input int busy_hit, input bit on_done,
                           output bit timed_out);
    int c = 0;
    timed_out = 1'b0;
    while (!done_s && c < budget) begin
      if (busy_hit >= 0 && nwords == busy_hit && !start) begin
        start = 1'b1;
        busy_hit = -1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    if (!done_s) timed_out = 1'b1;
    else if (on_done) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    asserts++; if (b0 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", b0); end
    asserts++; if (dn0 !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", dn0); end
    asserts++; if (r0 !== 1'b0) begin fails++; $display("FAIL reset_fb_rd got %b want 0", r0); end
    asserts++; if (a0 !== 10'd0) begin fails++; $display("FAIL reset_fb_addr got %0d want 0", a0); end
    asserts++; if (v0 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", v0); end
    asserts++; if (d0 !== 9'h000) begin fails++; $display("FAIL reset_out_data got %h want 000", d0); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_init_frame();
    bit to;
    int e;
    sel = 0; mode = 0; clear_counts();
    pulse_start(1'b1);
    wait_done(20000, -1, 1'b0, to);
    e = seq_errs(1'b1, 102, 0);
    asserts++; if (to) begin fails++; $display("FAIL init_timeout got no done want done"); end
    asserts++; if (nwords != 853) begin fails++; $display("FAIL init_count got %0d want 853", nwords); end
    asserts++; if (e != 0) begin fails++; $display("FAIL init_sequence got %0d bad words want 0", e); end
    asserts++; if (got.size() > 13 && got[13] !== 9'h1B0) begin fails++; $display("FAIL init_first_pre got %h want 1b0", got[13]); end
    asserts++; if (ndone != 1) begin fails++; $display("FAIL init_done_pulses got %0d want 1", ndone); end
    asserts++; if (b0 !== 1'b0) begin fails++; $display("FAIL init_busy_after got %b want 0", b0); end
    asserts++; if (nfbrd != 816) begin fails++; $display("FAIL init_fb_rd got %0d want 816", nfbrd); end
  endtask

  task automatic test_no_init_offset();
    bit to;
    int e;
    sel = 1; mode = 0; clear_counts();
    pulse_start(1'b0);
    wait_done(20000, -1, 1'b0, to);
    e = seq_errs(1'b0, 102, 30);
    asserts++; if (to) begin fails++; $display("FAIL off_timeout got no done want done"); end
    asserts++; if (nwords != 840) begin fails++; $display("FAIL off_count got %0d want 840", nwords); end
    asserts++; if (got.size() < 3 || got[0] !== 9'h1B0 || got[1] !== 9'h111 || got[2] !== 9'h10E) begin
      fails++;
      $display("FAIL off_preamble got %h %h %h want 1b0 111 10e",
               got.size() > 0 ? got[0] : 9'h0, got.size() > 1 ? got[1] : 9'h0,
               got.size() > 2 ? got[2] : 9'h0);
    end
    asserts++; if (e != 0) begin fails++; $display("FAIL off_sequence got %0d bad words want 0", e); end
  endtask

  task automatic test_backpressure();
    bit to;
    int e;
    sel = 0; mode = 1; clear_counts();
    pulse_start(1'b1);
    wait_done(40000, -1, 1'b0, to);
    e = seq_errs(1'b1, 102, 0);
    asserts++; if (to) begin fails++; $display("FAIL bp_timeout got no done want done"); end
    asserts++; if (nwords != 853) begin fails++; $display("FAIL bp_count got %0d want 853", nwords); end
    asserts++; if (e != 0) begin fails++; $display("FAIL bp_sequence got %0d bad words want 0", e); end
    asserts++; if (hold_viol != 0) begin fails++; $display("FAIL bp_hold got %0d changes want 0", hold_viol); end
    asserts++; if (nfbrd != 816) begin fails++; $display("FAIL bp_fb_rd got %0d want 816", nfbrd); end
    asserts++; if (!stalled_once) begin fails++; $display("FAIL bp_stall got no stall want stall"); end
    mode = 0;
  endtask

  task automatic test_back_to_back();
    bit to;
    int e;
    sel = 0; mode = 0; clear_counts();
    pulse_start(1'b1);
    wait_done(20000, 100, 1'b1, to);
    e = seq_errs(1'b1, 102, 0);
    asserts++; if (to) begin fails++; $display("FAIL b2b_timeout got no done want done"); end
    asserts++; if (nwords != 853) begin fails++; $display("FAIL b2b_count got %0d want 853", nwords); end
    asserts++; if (e != 0) begin fails++; $display("FAIL b2b_sequence got %0d bad words want 0", e); end
    asserts++; if (ndone != 1) begin fails++; $display("FAIL b2b_done_pulses got %0d want 1", ndone); end
    asserts++; if (b0 !== 1'b0) begin fails++; $display("FAIL b2b_start_at_done got busy %b want 0", b0); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int c = 0, e;
    sel = 0; mode = 0; clear_counts();
    pulse_start(1'b1);
    while (nwords < 400 && c < 5000) begin @(posedge clk); #1; c++; end
    rst = 1'b1;
    @(posedge clk); #1;
    asserts++; if (v0 !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b want 0", v0); end
    asserts++; if (b0 !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", b0); end
    rst = 1'b0;
    @(posedge clk); #1;
    clear_counts();
    pulse_start(1'b1);
    wait_done(20000, -1, 1'b0, to);
    e = seq_errs(1'b1, 102, 0);
    asserts++; if (to || nwords != 853) begin fails++; $display("FAIL rstmid_count got %0d want 853", nwords); end
    asserts++; if (e != 0) begin fails++; $display("FAIL rstmid_sequence got %0d bad words want 0", e); end
  endtask

  task automatic test_fifo();
    bit to;
    int c = 0, e;
    sel = 0; mode = 2; clear_counts();
    pulse_start(1'b1);
    wait_done(40000, -1, 1'b0, to);
    while (fifo_q.size() > 0 && c < 2000) begin @(posedge clk); #1; c++; end
    e = seq_errs(1'b1, 102, 0);
    asserts++; if (to || got.size() != 853) begin fails++; $display("FAIL fifo_count got %0d want 853", got.size()); end
    asserts++; if (e != 0) begin fails++; $display("FAIL fifo_sequence got %0d bad words want 0", e); end
    asserts++; if (full_hits == 0) begin fails++; $display("FAIL fifo_full got %0d full cycles want >0", full_hits); end
    mode = 0;
  endtask

  task automatic test_wrap();
    bit to;
    int e;
    sel = 2; mode = 0; clear_counts();
    pulse_start(1'b0);
    wait_done(5000, -1, 1'b0, to);
    e = seq_errs(1'b0, 16, 0);
    asserts++; if (to || nwords != 76) begin fails++; $display("FAIL wrap_count got %0d want 76", nwords); end
    asserts++; if (e != 0) begin fails++; $display("FAIL wrap_sequence got %0d bad words want 0", e); end
    asserts++; if (nfbrd != 64) begin fails++; $display("FAIL wrap_fb_rd got %0d want 64", nfbrd); end
    asserts++; if (a2 !== 6'd0) begin fails++; $display("FAIL wrap_fb_addr got %0d want 0", a2); end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_init_frame();
    test_no_init_offset();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_fifo();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/lcd_frame_streamer.md
Name: lcd_frame_streamer

Overview:
- Upstream feeder for the LCD SPI peripheral's 9-bit command/data FIFO.
- On a start pulse it optionally emits the controller power-up init sequence. It then walks a byte-organised framebuffer page by page.
- For each page it emits a page/column address preamble followed by COLS data bytes.
- Output is a valid/ready word stream that connects directly to the FIFO write side: out_ready = ~full.

Parameters:
- COLS, 102, columns per page (data bytes per page).
- PAGES, 8, pages per frame (8 pixel rows each).
- COL_OFFSET, 0, constant added to the column address sent in the preamble (0..131).
- FB_AW, 10, framebuffer address width; must satisfy 2^FB_AW >= COLS*PAGES.

Ports:
- clk  in  1  system clock (Bus2IP_Clk domain).
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to stream one frame; ignored while busy=1.
- init_en  in  1  sampled with start; 1 = send init sequence before the frame.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last frame word is accepted.
- fb_rd  out  1  framebuffer read strobe.
- fb_addr  out  FB_AW  framebuffer byte address.
- fb_rdata  in  8  read data, valid exactly 1 cycle after fb_rd.
- out_data  out  9  bit8 = inst_notdata (1 = instruction, 0 = display data), bits7:0 = byte.
- out_valid  out  1  out_data holds a word to transfer.
- out_ready  in  1  sink can accept; a transfer occurs in a cycle where out_valid & out_ready.

Behaviour:
- Reset values: busy=0, done=0, fb_rd=0, fb_addr=0, out_valid=0, out_data=0; internal state IDLE, all counters 0. Reset mid-frame aborts immediately; no partial word is held.
- Handshake: once out_valid rises, out_data is stable and out_valid stays high until a transfer. There is no combinational path from out_ready to out_valid or out_data. The next word is loaded at the earliest in the cycle after the transfer.
- States:
  - IDLE: on start, latch init_en, set busy=1. Go to INIT if init_en=1, else PRE.
  - INIT: present rom[idx] with bit8=1. On each transfer idx++. After idx = INIT_LEN-1 is transferred, go to PRE.
  - PRE: three instruction words per page, in order:
    - 0xB0|page
    - 0x10|(col_addr[7:4])
    - 0x00|(col_addr[3:0])
    - col_addr = COL_OFFSET.
    - After the third word is transferred, go to FETCH.
  - FETCH: assert fb_rd for one cycle with the current fb_addr, then go to LATCH.
  - LATCH: capture fb_rdata into out_data with bit8=0, set out_valid, go to SEND.
  - SEND: on transfer, fb_addr++ and col++.
    - col < COLS-1 -> FETCH.
    - col = COLS-1 and page < PAGES-1 -> col=0, page++, PRE.
    - col = COLS-1 and page = PAGES-1 -> DONE.
  - DONE: pulse done=1, set busy=0, clear counters and fb_addr, go to IDLE.
- fb_addr advances linearly 0..COLS*PAGES-1; there is no multiplier.
- Word counts:
  - With init: INIT_LEN + PAGES*(3+COLS) words. With defaults, 13 + 8*105 = 853.
  - Without init: 840.
- Throughput: at most one data word per 3 cycles, which is far above the SPI drain rate.
- Boundary conditions:
  - start while busy: ignored; no state change.
  - start in the same cycle as done: ignored.
  - out_ready low indefinitely: the block stalls in INIT, PRE or SEND with the word held. It issues no extra fb_rd.
  - COLS*PAGES = 2^FB_AW exactly: fb_addr wraps to 0 at DONE only.

Decomposition:
- Shared include lcd_defs.vh (the team's package equivalent) holds:
  - state encodings;
  - INIT_LEN = 13;
  - init bytes: 0x40, 0xA1, 0xC0, 0xA4, 0xA6, 0xA2, 0x2F, 0x27, 0x81, 0x10, 0xFA, 0x90, 0xAF;
  - instruction opcodes PAGE_ADDR = 0xB0, COL_HI = 0x10, COL_LO = 0x00;
  - the bit8 instruction flag.
- One sub-module: lcd_init_rom, a combinational 4-bit index -> 8-bit byte case ROM.

Test Plan:
- Init + frame: rst, then start with init_en=1, out_ready=1, framebuffer filled with fb[i] = i[7:0].
  - Expect 853 words: the 13 ROM bytes with bit8=1.
  - Then, per page p: 0x1B0+p, 0x110, 0x100, followed by 102 data words equal to (p*102+c)[7:0] with bit8=0.
  - done pulses once; busy is low afterwards.
- No init, COL_OFFSET=30: expect exactly 840 words. The first three are 0x1B0, 0x111, 0x10E.
- Backpressure: random out_ready, roughly 30% high, plus a 500-cycle low stall mid-page.
  - Word sequence is identical to the out_ready=1 run.
  - out_data never changes while out_valid=1 and out_ready=0.
  - fb_rd count is exactly 816.
- Start while busy: pulse start at word 100. Word count and sequence are unchanged; exactly one done pulse.
- Reset mid-frame: assert rst at word 400 during SEND. The next cycle shows out_valid=0 and busy=0. A subsequent start produces a full, correct 853-word frame.
- FIFO integration: connect to the LCD SPI peripheral's FIFO model with out_ready = ~full. No word is lost or duplicated across 16-deep full/empty cycling.
